// File: rtl/cfg_update_pkg.sv
// Shared FSM state type and width helpers for the configuration write controller.
package cfg_update_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_Q,
        COMMIT,
        RESP
    } cfg_state_t;

    function automatic int cfg_addr_w(input int nregs);
        return (nregs <= 2) ? 1 : $clog2(nregs);
    endfunction

    // A zero timeout still needs a legal one-bit counter even though it never fires.
    function automatic int cfg_cnt_w(input int timeout);
        return (timeout <= 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/cfg_req_fifo.sv
// Two-entry synchronous FIFO holding pending configuration requests.
module cfg_req_fifo #(
    parameter int DW = 8
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic [1:0]    count
);

    logic [DW-1:0] mem [2];
    logic          wr_ptr;
    logic          rd_ptr;

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/cfg_update_ctrl.sv
// Buffers config writes and commits each one as a one-cycle load-enable pulse once downstream is quiescent.
// Optional readback of cfg_q is enabled by defining CFG_READBACK_EN.
module cfg_update_ctrl
    import cfg_update_pkg::*;
#(
    parameter  int WIDTH   = 32,
    parameter  int NREGS   = 8,
    parameter  int TIMEOUT = 256,
    localparam int ADDR_W  = cfg_addr_w(NREGS)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic                   req_write,
    input  logic [ADDR_W-1:0]      req_addr,
    input  logic [WIDTH-1:0]       req_data,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_err,
    output logic [WIDTH-1:0]       rsp_data,
    input  logic                   quiesce,
    output logic [NREGS-1:0]       cfg_en,
    output logic [WIDTH-1:0]       cfg_d,
    input  logic [NREGS*WIDTH-1:0] cfg_q
);

    localparam int CNT_W = cfg_cnt_w(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [WIDTH-1:0]  data;
    } req_t;

    cfg_state_t        state;
    req_t              push_req;
    req_t              head;
    logic [1:0]        fifo_count;
    logic              push;
    logic              pop;
    logic              addr_bad;
    logic              head_is_read;
    logic [CNT_W-1:0]  cnt;
    logic [ADDR_W-1:0] hold_addr;
    logic [WIDTH-1:0]  hold_data;

    assign req_ready = (fifo_count < 2'd2);
    assign push      = req_valid && req_ready;
    assign pop       = (state == IDLE) && (fifo_count != 2'd0);
    assign addr_bad  = (int'(head.addr) >= NREGS);
    assign cfg_d     = hold_data;

    assign push_req.addr = req_addr;
    assign push_req.data = req_data;

`ifdef CFG_READBACK_EN
    logic [WIDTH-1:0] rd_data;

    assign push_req.write = req_write;
    assign head_is_read   = !head.write;
    assign rsp_data       = rd_data;

    // Read data is captured at pop and held untouched until the next request is popped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            rd_data <= '0;
        end else if (pop) begin
            rd_data <= (head.write || addr_bad) ? '0 : cfg_q[int'(head.addr)*WIDTH +: WIDTH];
        end
    end
`else
    logic unused_inputs;

    assign push_req.write = 1'b1;
    assign head_is_read   = 1'b0;
    assign rsp_data       = '0;
    assign unused_inputs  = ^{req_write, head.write, cfg_q};
`endif

    cfg_req_fifo #(
        .DW($bits(req_t))
    ) u_fifo (
        .CLK   (CLK),
        .RST   (RST),
        .push  (push),
        .pop   (pop),
        .din   (push_req),
        .dout  (head),
        .count (fifo_count)
    );

    // cfg_en is registered on entry to COMMIT so it never depends combinationally on quiesce.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_addr <= '0;
            hold_data <= '0;
            cfg_en    <= '0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        hold_addr <= head.addr;
                        hold_data <= head.data;
                        cnt       <= '0;
                        if (addr_bad) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (head_is_read) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b0;
                        end else begin
                            state <= WAIT_Q;
                        end
                    end
                end
                WAIT_Q: begin
                    if (quiesce) begin
                        state  <= COMMIT;
                        cfg_en <= NREGS'(1) << hold_addr;
                    end else if (TIMEOUT != 0 && cnt == CNT_LAST) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_err   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                COMMIT: begin
                    cfg_en    <= '0;
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
